reg_gp_file: RTL and testbench

//   General-purpose register file for the amber pipeline.
//   - Supplies two combinational read ports to the forwarding unit: src operand -> read_data1, tgt operand -> read_data2.
//   - Accepts one write per cycle from the MO/WB stage.
//   - Clears itself after reset with a one-register-per-cycle sweep, so it maps onto distributed/block RAM with no wide reset fan-out.
//   - Asserts or_busy while clearing; decode stalls on or_busy.

---
 rtl/reg_gp_file.sv | 138 +++++++++++++
 tb/tb_reg_gp_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_gp_file.sv
// -----------------------------------------------------------------------------
// reg_gp_file
//   General-purpose register file for the amber pipeline.
//   Two combinational read ports feed the forwarding unit; one write port is
//   driven by the MO/WB latch. After reset the array is cleared by a sweep
//   that writes one register per cycle. This keeps the storage free of any
//   reset, so it can map onto distributed or block RAM. While the sweep runs,
//   or_busy is high, decode stalls, and both read ports return zero.
//
//   Build option:
//     REGFILE_WT_EN  when defined, a same-cycle write is forwarded to any read
//                    port whose index matches the write index (write-through).
//                    When undefined, reads return the pre-write contents.
//
// Ports
//   iw_clk            clock, all state changes on posedge
//   iw_rst            synchronous active-high reset, restarts the clear sweep
//   iw_src_gp         read port 1 index (source operand)
//   iw_tgt_gp         read port 2 index (target operand)
//   iw_wb_gp          write index from MO/WB
//   iw_wb_gp_we       write enable from MO/WB (ignored while clearing)
//   iw_wb_result      write data from MO/WB
//   or_gp_read_data1  reg[iw_src_gp], forced to 0 while busy
//   or_gp_read_data2  reg[iw_tgt_gp], forced to 0 while busy
//   or_busy           clear sweep in progress
// -----------------------------------------------------------------------------
module reg_gp_file #(
    parameter int NREG  = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 24
) (
    input  logic             iw_clk,
    input  logic             iw_rst,
    input  logic [AW-1:0]    iw_src_gp,
    input  logic [AW-1:0]    iw_tgt_gp,
    input  logic [AW-1:0]    iw_wb_gp,
    input  logic             iw_wb_gp_we,
    input  logic [WIDTH-1:0] iw_wb_result,
    output logic [WIDTH-1:0] or_gp_read_data1,
    output logic [WIDTH-1:0] or_gp_read_data2,
    output logic             or_busy
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    if (NREG != 2**AW) begin : g_size_check
        $error("reg_gp_file: NREG must equal 2**AW");
    end

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    clr_idx;
    logic [AW-1:0]    clr_idx_next;
    logic             busy_next;
    logic             wb_fire;
    logic [WIDTH-1:0] regs [NREG];

    // Writeback is only accepted once the sweep has finished.
    assign wb_fire = (state == S_READY) && iw_wb_gp_we;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        busy_next    = or_busy;
        case (state)
            S_CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_next   = S_READY;
                    clr_idx_next = '0;
                    busy_next    = 1'b0;
                end else begin
                    clr_idx_next = clr_idx + 1'b1;
                end
            end
            S_READY: begin
                busy_next = 1'b0;
            end
            default: begin
                state_next   = S_CLEAR;
                clr_idx_next = '0;
                busy_next    = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the clock edge.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            or_busy <= 1'b1;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
            or_busy <= busy_next;
        end
    end

    // NOTE: the array has no reset branch on purpose. The sweep clears it
    // one entry per cycle, which keeps it mappable onto RAM primitives.
    always_ff @(posedge iw_clk) begin
        if (state == S_CLEAR) begin
            regs[clr_idx] <= '0;
        end else if (wb_fire) begin
            regs[iw_wb_gp] <= iw_wb_result;
        end
    end

    // Read ports. Busy forcing wins over everything, including write-through.
    always_comb begin
        or_gp_read_data1 = regs[iw_src_gp];
        or_gp_read_data2 = regs[iw_tgt_gp];
`ifdef REGFILE_WT_EN
        if (wb_fire && (iw_wb_gp == iw_src_gp)) begin
            or_gp_read_data1 = iw_wb_result;
        end
        if (wb_fire && (iw_wb_gp == iw_tgt_gp)) begin
            or_gp_read_data2 = iw_wb_result;
        end
`else
        // Without write-through, the forwarding unit's MO/WB path covers
        // a read of the register being written in the same cycle.
`endif
        if (or_busy) begin
            or_gp_read_data1 = '0;
            or_gp_read_data2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_gp_file.sv
// -----------------------------------------------------------------------------
// tb_reg_gp_file
//   Self-checking bench for reg_gp_file. A behavioural model of the array and
//   of the clear sweep produces the expected read data and busy flag. These
//   values are queued when the stimulus is applied, then popped and compared
//   once the combinational outputs have settled. Define REGFILE_WT_EN for both
//   the bench and the RTL to check the write-through build.
// -----------------------------------------------------------------------------
module tb_reg_gp_file;

    localparam int NREG  = 16;
    localparam int AW    = 4;
    localparam int WIDTH = 24;

    logic             iw_clk = 1'b0;
    logic             iw_rst;
    logic [AW-1:0]    iw_src_gp;
    logic [AW-1:0]    iw_tgt_gp;
    logic [AW-1:0]    iw_wb_gp;
    logic             iw_wb_gp_we;
    logic [WIDTH-1:0] iw_wb_result;
    logic [WIDTH-1:0] or_gp_read_data1;
    logic [WIDTH-1:0] or_gp_read_data2;
    logic             or_busy;

    reg_gp_file #(.NREG(NREG), .AW(AW), .WIDTH(WIDTH)) dut (
        .iw_clk           (iw_clk),
        .iw_rst           (iw_rst),
        .iw_src_gp        (iw_src_gp),
        .iw_tgt_gp        (iw_tgt_gp),
        .iw_wb_gp         (iw_wb_gp),
        .iw_wb_gp_we      (iw_wb_gp_we),
        .iw_wb_result     (iw_wb_result),
        .or_gp_read_data1 (or_gp_read_data1),
        .or_gp_read_data2 (or_gp_read_data2),
        .or_busy          (or_busy)
    );

    always #5 iw_clk = ~iw_clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic             busy;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] m_regs [NREG];
    logic             m_busy;
    int               m_idx;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [WIDTH-1:0] exp_read(input logic [AW-1:0] idx);
        if (m_busy) return '0;
`ifdef REGFILE_WT_EN
        if (iw_wb_gp_we && (iw_wb_gp == idx)) return iw_wb_result;
`endif
        return m_regs[idx];
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare once the
    // outputs settle, then advance the model across the posedge.
    task automatic cycle(input string tag, input logic rst,
                         input logic [AW-1:0] src, input logic [AW-1:0] tgt,
                         input logic we, input logic [AW-1:0] wb,
                         input logic [WIDTH-1:0] data);
        exp_t e;
        iw_rst       = rst;
        iw_src_gp    = src;
        iw_tgt_gp    = tgt;
        iw_wb_gp_we  = we;
        iw_wb_gp     = wb;
        iw_wb_result = data;
        e.tag  = tag;
        e.rd1  = exp_read(src);
        e.rd2  = exp_read(tgt);
        e.busy = m_busy;
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".rd1"}, 32'(or_gp_read_data1), 32'(e.rd1));
        check({e.tag, ".rd2"}, 32'(or_gp_read_data2), 32'(e.rd2));
        check({e.tag, ".busy"}, 32'(or_busy), 32'(e.busy));
        @(posedge iw_clk);
        if (rst) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end else if (m_busy) begin
            m_regs[m_idx] = '0;
            if (m_idx == NREG - 1) begin
                m_busy = 1'b0;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
        end else if (we) begin
            m_regs[wb] = data;
        end
        @(negedge iw_clk);
    endtask

    task automatic idle(input string tag, input logic [AW-1:0] src, input logic [AW-1:0] tgt);
        cycle(tag, 1'b0, src, tgt, 1'b0, '0, '0);
    endtask

    // Run the sweep until busy drops. The cycle count is bounded and checked.
    task automatic run_sweep(input string tag, input logic we, input logic [AW-1:0] wb,
                             input logic [WIDTH-1:0] data);
        int cnt = 0;
        while (or_busy && cnt < 100) begin
            cycle($sformatf("%s[%0d]", tag, cnt), 1'b0, AW'(cnt), AW'(cnt + 5), we, wb, data);
            cnt++;
        end
        check({tag, ".busy_len"}, 32'(cnt), 32'(NREG));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iw_rst       = 1'b1;
        iw_src_gp    = '0;
        iw_tgt_gp    = '0;
        iw_wb_gp     = '0;
        iw_wb_gp_we  = 1'b0;
        iw_wb_result = '0;
        @(negedge iw_clk);
        @(posedge iw_clk);
        m_busy = 1'b1;
        m_idx  = 0;
        @(negedge iw_clk);

        // Test 1: sweep after reset, reads forced to zero, ready on cycle 17.
        run_sweep("sweep1", 1'b0, '0, '0);
        idle("ready1", 4'd0, 4'd15);

        // Test 2: write then read on both ports, plus an untouched register.
        cycle("wr5", 1'b0, 4'd1, 4'd2, 1'b1, 4'd5, 24'hABCDEF);
        idle("rd5", 4'd5, 4'd5);
        idle("rd6", 4'd6, 4'd5);

        // Test 3: same-cycle write/read on port 1, then port 2, then both.
        cycle("wt3", 1'b0, 4'd3, 4'd4, 1'b1, 4'd3, 24'h123456);
        idle("rd3", 4'd3, 4'd3);
        cycle("wt9", 1'b0, 4'd0, 4'd9, 1'b1, 4'd9, 24'h9A9A9A);
        cycle("wt0", 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 24'h000FFF);
        idle("rd9_0", 4'd9, 4'd0);

        // Test 4: fill every register, read them back, reset at index 0.
        for (int i = 0; i < NREG; i++) begin
            cycle($sformatf("fill%0d", i), 1'b0, AW'(i - 1), AW'(i + 3), 1'b1, AW'(i),
                  WIDTH'(24'h10_0000 + i * 24'h01_1111));
        end
        for (int i = 0; i < NREG; i += 2) begin
            idle($sformatf("chk%0d", i), AW'(i), AW'(i + 1));
        end
        cycle("rst2", 1'b1, 4'd4, 4'd7, 1'b0, '0, '0);
        run_sweep("sweep2", 1'b0, '0, '0);
        for (int i = 0; i < NREG; i += 2) begin
            idle($sformatf("zero%0d", i), AW'(i), AW'(i + 1));
        end

        // Test 5: reset mid-sweep at clr_idx 7 restarts a full sweep.
        // Test 6: writes attempted throughout that sweep are dropped.
        cycle("fill2", 1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 24'h555555);
        cycle("rst3", 1'b1, 4'd2, 4'd2, 1'b0, '0, '0);
        for (int i = 0; i < 7; i++) begin
            cycle($sformatf("part%0d", i), 1'b0, 4'd2, AW'(i), 1'b1, 4'd2, 24'h0F0F0F);
        end
        cycle("rst4", 1'b1, 4'd2, 4'd7, 1'b0, '0, '0);
        run_sweep("sweep3", 1'b1, 4'd2, 24'h0F0F0F);
        idle("rd2", 4'd2, 4'd2);

        // Random traffic with frequent index collisions.
        for (int i = 0; i < 80; i++) begin
            logic [AW-1:0] wb;
            wb = AW'($urandom_range(0, NREG - 1));
            cycle($sformatf("rnd%0d", i), 1'b0,
                  ($urandom_range(0, 3) == 0) ? wb : AW'($urandom_range(0, NREG - 1)),
                  ($urandom_range(0, 3) == 0) ? wb : AW'($urandom_range(0, NREG - 1)),
                  1'($urandom_range(0, 1)), wb, WIDTH'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
